// File: rtl/md_sched_pkg.sv
// Shared encodings and latencies for the mult/div scheduler.
package md_sched_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MULT_RUN = 2'd1,
        ST_DIV_RUN  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_sched_if.sv
// Issue/result bundle between the E-stage/hazard logic and the mult/div unit.
interface md_sched_if;
    import md_sched_pkg::*;

    logic              start;
    logic [OP_W-1:0]   md_op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              md_use_D;
    logic              busy;
    logic              stall_md;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, md_use_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, md_use_D,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath; div0 flags a divide with zero divisor.
module md_alu
    import md_sched_pkg::*;
(
    input  md_op_e            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi_res,
    output logic [DATA_W-1:0] lo_res,
    output logic              div0
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [DATA_W-1:0]   div_b;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   mag_q;
    logic [DATA_W-1:0]   mag_r;
    logic [DATA_W-1:0]   uns_q;
    logic [DATA_W-1:0]   uns_r;

    always_comb begin
        prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

        div0  = (b == '0) && ((op == OP_DIV) || (op == OP_DIVU));
        // Substitute a harmless divisor so the dividers never see zero
        div_b = (b == '0) ? DATA_W'(1) : b;

        // Signed divide via magnitudes: avoids tool-dependent -2^31 / -1 behaviour
        a_mag = a[DATA_W-1]     ? -a     : a;
        b_mag = div_b[DATA_W-1] ? -div_b : div_b;
        mag_q = a_mag / b_mag;
        mag_r = a_mag % b_mag;
        uns_q = a / div_b;
        uns_r = a % div_b;

        hi_res = '0;
        lo_res = '0;
        case (op)
            OP_MULT:  {hi_res, lo_res} = prod_s;
            OP_MULTU: {hi_res, lo_res} = prod_u;
            OP_DIV: begin
                lo_res = (a[DATA_W-1] ^ div_b[DATA_W-1]) ? -mag_q : mag_q;
                hi_res = a[DATA_W-1] ? -mag_r : mag_r;
            end
            OP_DIVU: begin
                lo_res = uns_q;
                hi_res = uns_r;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler: captures operands on issue, counts down the
// latency, then commits the md_alu result into HI/LO.
module md_sched
    import md_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    md_op_e            op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    md_op_e            op_in;
    logic [DATA_W-1:0] hi_res;
    logic [DATA_W-1:0] lo_res;
    logic              div0;

    assign op_in = md_op_e'(bus.md_op);

    md_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    // Issue, countdown and commit; starts outside IDLE fall through untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (op_in)
                            OP_MULT, OP_MULTU: begin
                                state <= ST_MULT_RUN;
                                cnt   <= CNT_W'(MULT_LAT);
                                op_q  <= op_in;
                                a_q   <= bus.rs_val;
                                b_q   <= bus.rt_val;
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= ST_DIV_RUN;
                                cnt   <= CNT_W'(DIV_LAT);
                                op_q  <= op_in;
                                a_q   <= bus.rs_val;
                                b_q   <= bus.rt_val;
                            end
                            OP_MTHI: hi_q <= bus.rs_val;
                            OP_MTLO: lo_q <= bus.rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_MULT_RUN, ST_DIV_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        if (!div0) begin
                            hi_q <= hi_res;
                            lo_q <= lo_res;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    // Arithmetic ops have md_op[2] clear; stall covers the issue cycle and the run
    assign bus.stall_md = bus.md_use_D & ((bus.start & ~bus.md_op[2]) | bus.busy);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: vector table + scoreboard queue, plus
// hand sequences for reset-while-busy.
module tb_md_sched;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_sched_if bus ();

    md_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_d;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
        int          inj_at;
        logic [2:0]  inj_op;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
        logic        use_d;
        int          inj_at;
        logic [2:0]  inj_op;
    } exp_t;

    vec_t        vecs [16];
    int          nv;
    exp_t        sb [$];
    int          checks;
    int          failures;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input logic [31:0] eh, input logic [31:0] el,
                       input int eb, input int inj_at, input logic [2:0] inj_op);
        vecs[nv] = '{op, a, b, use_d, eh, el, eb, inj_at, inj_op};
        nv++;
    endtask

    // Pop the expected result and follow the run until busy drops (bounded)
    task automatic drain();
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (bus.busy && n < 20) begin
            if (n == 0) begin
                chk("pre_op_hi", bus.hi, cur_hi);
                chk("pre_op_lo", bus.lo, cur_lo);
            end
            chk("stall_run", bus.stall_md, e.use_d);
            if (n == e.inj_at) begin
                bus.start  = 1'b1;
                bus.md_op  = e.inj_op;
                bus.rs_val = 32'h5555;
                bus.rt_val = 32'h3;
            end else begin
                bus.start  = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("busy_cycles", n, e.busy);
        chk("busy_low", bus.busy, 1'b0);
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        cur_hi = e.hi;
        cur_lo = e.lo;
        bus.md_use_D = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.md_op    = v.op;
        bus.rs_val   = v.a;
        bus.rt_val   = v.b;
        bus.md_use_D = v.use_d;
        #1;
        chk("stall_issue", bus.stall_md, v.use_d & ~v.op[2]);
        e = '{v.exp_hi, v.exp_lo, v.exp_busy, v.use_d, v.inj_at, v.inj_op};
        sb.push_back(e);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        drain();
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        nv       = 0;
        bus.start    = 1'b0;
        bus.md_op    = 3'd0;
        bus.rs_val   = 32'h0;
        bus.rt_val   = 32'h0;
        bus.md_use_D = 1'b0;
        reset        = 1'b1;

        //  op     a             b             use  hi            lo            busy inj inj_op
        add(3'd0, 32'hFFFFFFFE, 32'h3,        0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5,  -1, 3'd0);
        add(3'd2, 32'hFFFFFFF9, 32'h2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, -1, 3'd0);
        add(3'd4, 32'h11,       32'h0,        0, 32'h11,       32'hFFFFFFFD, 0,  -1, 3'd0);
        add(3'd5, 32'h22,       32'h0,        0, 32'h11,       32'h22,       0,  -1, 3'd0);
        add(3'd3, 32'h5,        32'h0,        0, 32'h11,       32'h22,       10, -1, 3'd0);
        add(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h1,        5,  -1, 3'd0);
        add(3'd3, 32'd100,      32'd7,        0, 32'h2,        32'hE,        10, 3,  3'd4);
        add(3'd2, 32'h7,        32'hFFFFFFFE, 0, 32'h1,        32'hFFFFFFFD, 10, 5,  3'd0);
        add(3'd0, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0,        5,  -1, 3'd0);
        add(3'd1, 32'h10000,    32'h10000,    0, 32'h1,        32'h0,        5,  -1, 3'd0);
        add(3'd6, 32'hDEAD,     32'h1,        1, 32'h1,        32'h0,        0,  -1, 3'd0);
        add(3'd7, 32'hBEEF,     32'h1,        0, 32'h1,        32'h0,        0,  -1, 3'd0);
        add(3'd4, 32'hABCD,     32'h0,        0, 32'hABCD,     32'h0,        0,  -1, 3'd0);
        add(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0,        32'h80000000, 10, -1, 3'd0);
        add(3'd2, 32'hFFFFFFF9, 32'h0,        1, 32'h0,        32'h80000000, 10, -1, 3'd0);
        add(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, 32'h3,        10, -1, 3'd0);

        // Reset state
        #1;
        chk("rst_busy",  bus.busy, 1'b0);
        chk("rst_stall", bus.stall_md, 1'b0);
        chk("rst_hi",    bus.hi, 32'h0);
        chk("rst_lo",    bus.lo, 32'h0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            issue(vecs[i]);
        end

        // Reset during busy cycle 3 of a MULT aborts with no commit
        @(negedge clk);
        bus.start  = 1'b1;
        bus.md_op  = 3'd0;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd4;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_hi",   bus.hi, 32'h0);
        chk("abort_lo",   bus.lo, 32'h0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_commit_hi", bus.hi, 32'h0);
        chk("abort_no_commit_lo", bus.lo, 32'h0);

        v = '{3'd0, 32'd6, 32'd7, 1'b1, 32'h0, 32'd42, 5, -1, 3'd0};
        issue(v);

        // Start on the first edge after reset release
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        v = '{3'd1, 32'hFFFFFFFF, 32'h2, 1'b0, 32'h1, 32'hFFFFFFFE, 5, -1, 3'd0};
        issue(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 start  input  1  E-stage valid mult/div issue strobe, one cycle per instruction.
REQ-004 md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others NOP.
REQ-005 rs_val  input  32  forwarded E-stage rs operand.
REQ-006 rt_val  input  32  forwarded E-stage rt operand.
REQ-007 md_use_D  input  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 busy  output  1  unit is executing a multi-cycle op.
REQ-009 stall_md  output  1  stall request to the hazard unit.
REQ-010 hi  output  32  architectural HI.
REQ-011 lo  output  32  architectural LO.

Function
REQ-012 FSM states SHALL be IDLE, MULT_RUN, DIV_RUN.
REQ-013 Transitions:
- IDLE + start + md_op MULT/MULTU -> MULT_RUN, counter loaded with 5.
- IDLE + start + md_op DIV/DIVU -> DIV_RUN, counter loaded with 10.
REQ-014 In MULT_RUN or DIV_RUN, the counter SHALL decrement by 1 per cycle; on the edge where counter==1 the FSM SHALL return to IDLE and commit the result to HI/LO.
REQ-015 busy SHALL be 1 exactly while the state is not IDLE: 5 cycles after MULT issue, 10 cycles after DIV issue.
REQ-016 Operands SHALL be captured on the start edge; later changes to rs_val/rt_val SHALL NOT affect the result.
REQ-017 MULT: {hi,lo} = signed 64-bit product.
REQ-018 MULTU: {hi,lo} = unsigned 64-bit product.
REQ-019 DIV: lo = signed quotient, truncated toward zero; hi = remainder with the sign of the dividend.
REQ-020 DIVU: lo = unsigned quotient; hi = unsigned remainder.
REQ-021 DIV/DIVU with rt_val==0 SHALL run the full 10 cycles and leave HI/LO unchanged.
REQ-022 MTHI/MTLO with start SHALL write rs_val to hi/lo on that edge, SHALL NOT set busy, and SHALL require the unit to be IDLE.
REQ-023 start while busy SHALL be ignored, with no state or HI/LO change.
REQ-024 stall_md = md_use_D & (start & md_op in {0..3} | busy), combinational.
REQ-025 hi/lo SHALL be readable at all times and SHALL show the pre-op values until the commit edge.
REQ-026 Unused md_op codes (6, 7) with start SHALL be NOPs.

Reset
REQ-027 Asserting reset SHALL force state to IDLE, counter=0, busy=0, hi=0, lo=0, and the captured operands to 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit.
REQ-029 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-030 The shared package SHALL hold the md_op encodings, state encodings, MULT_LAT=5 and DIV_LAT=10.
REQ-031 The arithmetic SHALL be a combinational sub-module md_alu (op, a, b -> hi_res, lo_res, div0). It SHALL be evaluated on the captured operands, and its result SHALL be committed only at completion.
REQ-032 The counter SHALL be 4 bits wide; no other pipeline state is permitted.

Verification
REQ-033 Reset, then MULT with rs=0xFFFFFFFE, rt=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIV with rs=-7, rt=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU with rt=0 while hi=0x11, lo=0x22 -> 10 busy cycles; hi/lo remain 0x11/0x22.
REQ-036 MULTU with 0xFFFFFFFF x 0xFFFFFFFF, and md_use_D=1 during the run -> stall_md=1 on the issue cycle and all 5 busy cycles; then hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MTHI with rs=0xABCD while idle -> hi=0xABCD next edge, busy stays 0; a second start issued during a DIV is ignored.
REQ-038 Reset asserted at busy cycle 3 of a MULT -> busy=0, hi=lo=0 immediately; a new MULT issued afterwards completes normally.
